// File: rtl/fp_in_deser.sv
// Byte-serial operand deserializer for a double-precision multiplier: collects a
// 16-byte frame (A then B, LSB first), classifies both operands and holds them for a handshake.
module fp_in_deser #(
  parameter int BYTES_PER_OP = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      ENABLE,
  input  logic [7:0]                DATA_IN,
  input  logic                      OP_READY,
  output logic                      OP_VALID,
  output logic [8*BYTES_PER_OP-1:0] OP_A,
  output logic [8*BYTES_PER_OP-1:0] OP_B,
  output logic [2:0]                CLASS_A,
  output logic [2:0]                CLASS_B,
  output logic                      RES_NAN,
  output logic                      FRAME_ERR,
  output logic                      OVERRUN
);

  localparam int         OP_W = 8 * BYTES_PER_OP;
  localparam logic [2:0] LAST = 3'(BYTES_PER_OP - 1);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;

  state_t          state, state_nxt;
  logic [2:0]      cnt, cnt_nxt;
  logic            ld_a, ld_b, commit;
  logic            vld_nxt, ferr_nxt, ovr_nxt;
  logic [OP_W-1:0] sh_a, sh_b;
  logic [OP_W-1:0] b_full;
  logic [2:0]      cls_a, cls_b;

  // Returns {NAN, INF, ZERO}; subnormals and normals report 000.
  function automatic logic [2:0] classify(input logic [OP_W-1:0] x);
    logic exp_max, exp_zero, frac_zero;
    exp_max   = &x[62:52];
    exp_zero  = ~|x[62:52];
    frac_zero = ~|x[51:0];
    return {exp_max & ~frac_zero, exp_max & frac_zero, exp_zero & frac_zero};
  endfunction

  function automatic logic product_nan(input logic [2:0] ca, input logic [2:0] cb);
    return ca[2] | cb[2] | (ca[1] & cb[0]) | (ca[0] & cb[1]);
  endfunction

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      OP_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      OP_VALID  <= vld_nxt;
      FRAME_ERR <= ferr_nxt;
      OVERRUN   <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    commit    = 1'b0;
    vld_nxt   = OP_VALID;
    ferr_nxt  = 1'b0;
    ovr_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (ENABLE) begin
          ld_a      = 1'b1;
          cnt_nxt   = 3'd1;
          state_nxt = LOAD_A;
        end
      end
      LOAD_A: begin
        if (ENABLE) begin
          ld_a = 1'b1;
          if (cnt == LAST) begin
            cnt_nxt   = 3'd0;
            state_nxt = LOAD_B;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end else begin
          cnt_nxt   = 3'd0;
          ferr_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      LOAD_B: begin
        if (ENABLE) begin
          ld_b = 1'b1;
          if (cnt == LAST) begin
            cnt_nxt   = 3'd0;
            commit    = 1'b1;
            vld_nxt   = 1'b1;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end else begin
          cnt_nxt   = 3'd0;
          ferr_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        ovr_nxt = ENABLE;
        if (OP_READY) begin
          vld_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers move only on accepted bytes; the newest byte enters at the top.
  always_ff @(posedge CLK) begin
    if (ld_a) sh_a <= {DATA_IN, sh_a[OP_W-1:8]};
    if (ld_b) sh_b <= {DATA_IN, sh_b[OP_W-1:8]};
  end

  // The final B byte is still on DATA_IN at the commit edge, so fold it in here.
  assign b_full = {DATA_IN, sh_b[OP_W-1:8]};
  assign cls_a  = classify(sh_a);
  assign cls_b  = classify(b_full);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      OP_A    <= '0;
      OP_B    <= '0;
      CLASS_A <= 3'b001;
      CLASS_B <= 3'b001;
      RES_NAN <= 1'b0;
    end else if (commit) begin
      OP_A    <= sh_a;
      OP_B    <= b_full;
      CLASS_A <= cls_a;
      CLASS_B <= cls_b;
      RES_NAN <= product_nan(cls_a, cls_b);
    end
  end

endmodule

// File: tb/tb_fp_in_deser.sv
// Bench for fp_in_deser: table of operand pairs with hand-computed classes fed
// through a scoreboard, plus hold/overrun, abort and reset sequences.
module tb_fp_in_deser;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic [7:0]  DATA_IN = 8'h00;
  logic        OP_READY = 1'b1;
  logic        OP_VALID;
  logic [63:0] OP_A, OP_B;
  logic [2:0]  CLASS_A, CLASS_B;
  logic        RES_NAN, FRAME_ERR, OVERRUN;

  fp_in_deser #(.BYTES_PER_OP(8)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DATA_IN(DATA_IN),
    .OP_READY(OP_READY), .OP_VALID(OP_VALID), .OP_A(OP_A), .OP_B(OP_B),
    .CLASS_A(CLASS_A), .CLASS_B(CLASS_B), .RES_NAN(RES_NAN),
    .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  ca;
    logic [2:0]  cb;
    logic        nan;
  } vec_t;

  vec_t vecs[8];
  vec_t sbq[$];
  vec_t mon_e;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  logic prev_vld = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, OP_VALID, 1'b0);
    chk({tag, "_ops"}, {OP_A, OP_B}, 128'd0);
    chk({tag, "_class"}, {CLASS_A, CLASS_B, RES_NAN}, {3'b001, 3'b001, 1'b0});
    chk({tag, "_pulses"}, {FRAME_ERR, OVERRUN}, 2'b00);
  endtask

  task automatic send_byte(input logic [7:0] d);
    ENABLE  = 1'b1;
    DATA_IN = d;
    @(posedge CLK);
    #1;
  endtask

  // Drives a full frame, queues its expectation and checks the one-cycle latency.
  task automatic send_frame(input vec_t v);
    sbq.push_back(v);
    for (int i = 0; i < 8; i++) send_byte(v.a[8*i +: 8]);
    for (int i = 0; i < 7; i++) send_byte(v.b[8*i +: 8]);
    chk("no_early_valid", OP_VALID, 1'b0);
    send_byte(v.b[63:56]);
    chk("valid_latency", OP_VALID, 1'b1);
  endtask

  always @(negedge CLK) begin
    if (FRAME_ERR) ferr_cnt++;
    if (OVERRUN) ovr_cnt++;
    if (OP_VALID && !prev_vld) begin
      if (sbq.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid: got OP_A=%h OP_B=%h with nothing expected", OP_A, OP_B);
      end else begin
        mon_e = sbq.pop_front();
        chk("op_ab", {OP_A, OP_B}, {mon_e.a, mon_e.b});
        chk("class_nan", {CLASS_A, CLASS_B, RES_NAN}, {mon_e.ca, mon_e.cb, mon_e.nan});
      end
    end
    prev_vld = OP_VALID;
  end

  initial begin
    logic [127:0] held;
    int           ovr0;

    vecs[0] = '{64'h3FF8000000000000, 64'h4000000000000000, 3'b000, 3'b000, 1'b0};
    vecs[1] = '{64'h7FF0000000000000, 64'h0000000000000000, 3'b010, 3'b001, 1'b1};
    vecs[2] = '{64'h7FF8000000000000, 64'h8000000000000000, 3'b100, 3'b001, 1'b1};
    vecs[3] = '{64'h0000000000000000, 64'hFFF0000000000000, 3'b001, 3'b010, 1'b1};
    vecs[4] = '{64'h0000000000000001, 64'h7FF0000000000001, 3'b000, 3'b100, 1'b1};
    vecs[5] = '{64'h8000000000000000, 64'h0000000000000000, 3'b001, 3'b001, 1'b0};
    vecs[6] = '{64'hFFF0000000000000, 64'h3FF0000000000000, 3'b010, 3'b000, 1'b0};
    vecs[7] = '{64'h7FF0000000000000, 64'h7FF0000000000000, 3'b010, 3'b010, 1'b0};

    // Asynchronous reset, asserted before the first clock edge.
    #2 RESET = 1'b0;
    #1 check_reset("rst_async");
    @(posedge CLK);
    #1 RESET = 1'b1;

    // Back-to-back frames, one idle (handshake) cycle between them.
    for (int k = 0; k < 8; k++) begin
      send_frame(vecs[k]);
      ENABLE = 1'b0;
      @(posedge CLK);
      #1 chk("handshake_drop", OP_VALID, 1'b0);
    end

    // Hold with OP_READY low and one stray byte.
    OP_READY = 1'b0;
    ovr0 = ovr_cnt;
    send_frame(vecs[2]);
    held = {OP_A, OP_B};
    for (int c = 0; c < 5; c++) begin
      ENABLE  = (c == 2);
      DATA_IN = 8'hA5;
      @(posedge CLK);
      #1;
      chk("hold_valid", OP_VALID, 1'b1);
      chk("hold_stable", {OP_A, OP_B}, held);
      if (c == 2) chk("overrun_pulse", OVERRUN, 1'b1);
      if (c == 3) chk("overrun_end", OVERRUN, 1'b0);
    end
    ENABLE   = 1'b0;
    OP_READY = 1'b1;
    @(posedge CLK);
    #1 chk("hold_release", OP_VALID, 1'b0);
    chk("overrun_count", ovr_cnt - ovr0, 1);

    // Abort after 11 bytes.
    for (int i = 0; i < 11; i++) send_byte(8'h11 * i[7:0]);
    ENABLE = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort_ferr", FRAME_ERR, 1'b1);
    chk("abort_no_valid", OP_VALID, 1'b0);
    chk("abort_keep_ops", {OP_A, OP_B}, held);
    @(posedge CLK);
    #1 chk("abort_ferr_end", FRAME_ERR, 1'b0);
    send_frame(vecs[0]);
    ENABLE = 1'b0;
    @(posedge CLK);
    #1;

    // Reset after 4 bytes of a frame.
    for (int i = 0; i < 4; i++) send_byte(8'hC3);
    #2 RESET = 1'b0;
    ENABLE = 1'b0;
    #1 check_reset("rst_midframe");
    @(posedge CLK);
    #1 RESET = 1'b1;
    send_frame(vecs[1]);
    ENABLE = 1'b0;
    @(posedge CLK);
    #1;

    // Reset while holding.
    OP_READY = 1'b0;
    send_frame(vecs[3]);
    ENABLE = 1'b0;
    @(posedge CLK);
    #3 RESET = 1'b0;
    #1 check_reset("rst_hold");
    @(posedge CLK);
    #1 RESET = 1'b1;
    OP_READY = 1'b1;
    send_frame(vecs[4]);
    ENABLE = 1'b0;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;

    chk("queue_drained", sbq.size(), 0);
    chk("ferr_total", ferr_cnt, 1);
    chk("ovr_total", ovr_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fp_in_deser.md
FP_IN_DESER -- requirements
Module: fp_in_deser

Interface
REQ-001 SHALL have parameter BYTES_PER_OP, default 8: bytes per operand; operand width = 8*BYTES_PER_OP = 64.
REQ-002 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ENABLE  input  1  byte strobe; DATA_IN valid when high.
REQ-005 SHALL have port DATA_IN  input  8  serial operand byte.
REQ-006 SHALL have port OP_READY  input  1  downstream multiplier core accepts operands.
REQ-007 SHALL have port OP_VALID  output  1  OP_A/OP_B/class flags valid.
REQ-008 SHALL have port OP_A  output  64  operand A, IEEE-754 double.
REQ-009 SHALL have port OP_B  output  64  operand B, IEEE-754 double.
REQ-010 SHALL have port CLASS_A  output  3  {NAN, INF, ZERO} of OP_A.
REQ-011 SHALL have port CLASS_B  output  3  {NAN, INF, ZERO} of OP_B.
REQ-012 SHALL have port RES_NAN  output  1  product is NaN (either operand NaN, or Inf*0).
REQ-013 SHALL have port FRAME_ERR  output  1  one-cycle pulse: frame aborted.
REQ-014 SHALL have port OVERRUN  output  1  one-cycle pulse: byte dropped while holding.

Function
REQ-015 Frame SHALL be 16 consecutive ENABLE-high cycles: 8 bytes of A, then 8 bytes of B, each least-significant byte first (byte i -> bits [8i+7:8i]).
REQ-016 SHALL sample DATA_IN on each rising CLK where ENABLE=1; no sampling when ENABLE=0.
REQ-017 FSM states SHALL be IDLE, LOAD_A, LOAD_B, HOLD; 3-bit byte counter 0..7.
REQ-018 IDLE: ENABLE=1 -> store byte 0 of A, counter=1, go LOAD_A.
REQ-019 LOAD_A: ENABLE=1 -> store byte; counter 7 -> counter wraps to 0, go LOAD_B.
REQ-020 LOAD_B: ENABLE=1 -> store byte; at counter 7 -> load OP_A/OP_B/CLASS/RES_NAN from shift registers, OP_VALID=1, go HOLD.
REQ-021 Latency: OP_VALID SHALL be high in the cycle immediately after the edge sampling byte 15.
REQ-022 OP_A, OP_B, CLASS_A, CLASS_B, RES_NAN SHALL update only on frame completion and stay stable while OP_VALID=1 and afterwards until the next completion.
REQ-023 HOLD: on an edge with OP_READY=1, OP_VALID SHALL fall and FSM return to IDLE; OP_READY ignored when OP_VALID=0.
REQ-024 HOLD with ENABLE=1 (including the handshake edge): byte SHALL be dropped, OVERRUN pulsed one cycle, no state change beyond REQ-023.
REQ-025 ENABLE=0 in LOAD_A or LOAD_B SHALL abort: partial data discarded, counter=0, FRAME_ERR pulsed one cycle, go IDLE; outputs keep previous values.
REQ-026 Class per operand: NAN = exp==7FF and frac!=0; INF = exp==7FF and frac==0; ZERO = exp==0 and frac==0; subnormals flag none; at most one bit set.
REQ-027 RES_NAN = NAN_A | NAN_B | (INF_A & ZERO_B) | (ZERO_A & INF_B).
REQ-028 Shift registers SHALL not toggle when ENABLE=0 (low-power: no free-running load).

Reset
REQ-029 RESET low SHALL immediately force IDLE, counter 0, OP_VALID=0, FRAME_ERR=0, OVERRUN=0, OP_A=OP_B=0, CLASS_A=CLASS_B=3'b001, RES_NAN=0.
REQ-030 Reset mid-frame or in HOLD SHALL discard all data without FRAME_ERR; first ENABLE byte after release is byte 0 of A.

Verification
REQ-031 A=3FF8000000000000 bytes 00,00,00,00,00,00,F8,3F then B=4000000000000000, OP_READY=1 -> OP_VALID one cycle after byte 15, OP_A/OP_B match, CLASS both 000, RES_NAN=0.
REQ-032 A=7FF0000000000000, B=0000000000000000 -> CLASS_A=010, CLASS_B=001, RES_NAN=1.
REQ-033 A=7FF8000000000000, B=8000000000000000, OP_READY=0 for 5 cycles with ENABLE pulsed once in HOLD -> OP_VALID held 5+ cycles, outputs stable, OVERRUN one pulse, then handshake -> IDLE.
REQ-034 ENABLE drops after 11 bytes -> FRAME_ERR one-cycle pulse, no OP_VALID; next full 16-byte frame captured correctly.
REQ-035 RESET low after 4 bytes and in HOLD -> outputs at REQ-029 values asynchronously, no FRAME_ERR; subsequent frame correct.
REQ-036 Back-to-back frames separated by one idle cycle, OP_READY=1 -> two OP_VALID pulses, operands in order.
